// File: rtl/img_pattern_gen.sv
// Test-pattern source for the img_d/img_fv/img_lv capture interface: IDLE/VBLANK/FRONT/LINE/HBLANK/END sequencer.
// Outputs are registered one cycle behind the sequencer state; there is no backpressure and the source free-runs while en is high.
module img_pattern_gen #(
   parameter int ImageWidth  = 256,
   parameter int ImageHeight = 256,
   parameter int PixelWidth  = 12,
   parameter int VBlank      = 16,
   parameter int FrontPorch  = 16,
   parameter int HBlank      = 16,
   parameter int GridPitch   = 4
) (
   input  logic                  clk,
   input  logic                  rst_,
   input  logic                  en,
   input  logic [1:0]            mode,
   input  logic [PixelWidth-1:0] const_val,
   output logic [PixelWidth-1:0] img_d,
   output logic                  img_fv,
   output logic                  img_lv,
   output logic                  frame_done,
   output logic [15:0]           frame_cnt
);

   localparam int M1     = (VBlank > FrontPorch) ? VBlank : FrontPorch;
   localparam int M2     = (HBlank > ImageWidth) ? HBlank : ImageWidth;
   localparam int CntMax = (M1 > M2) ? M1 : M2;
   localparam int CntW   = $clog2(CntMax + 1);
   localparam int RowW   = $clog2(ImageHeight + 1);
   localparam int PxW    = $clog2(ImageWidth * ImageHeight + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_VBLANK,
      S_FRONT,
      S_LINE,
      S_HBLANK,
      S_END
   } state_t;

   state_t                state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [RowW-1:0]       row_q, row_d;
   logic [PxW-1:0]        px_q, px_d;
   logic [1:0]            mode_q, mode_d;
   logic [PixelWidth-1:0] cval_q, cval_d;

   logic [PixelWidth-1:0] img_d_q, img_d_d;
   logic                  img_fv_q, img_fv_d;
   logic                  img_lv_q, img_lv_d;
   logic                  frame_done_q, frame_done_d;
   logic [15:0]           frame_cnt_q, frame_cnt_d;

   logic                  vb_last;
   logic [PixelWidth-1:0] pix_val;

   // In LINE the phase counter doubles as the column index.
   always_comb begin
      pix_val = '0;
      case (mode_q)
         2'd0: pix_val = PixelWidth'(px_q);
         2'd1: begin
            if (((32'(row_q) % GridPitch) == 0) && ((32'(cnt_q) % GridPitch) == 0)) begin
               pix_val = '1;
            end
         end
         2'd2: pix_val = cval_q;
         default: pix_val = PixelWidth'(32'(row_q) + 32'(cnt_q));
      endcase
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      row_d        = row_q;
      px_d         = px_q;
      mode_d       = mode_q;
      cval_d       = cval_q;
      vb_last      = 1'b0;
      img_d_d      = '0;
      img_fv_d     = 1'b0;
      img_lv_d     = 1'b0;
      frame_done_d = 1'b0;
      frame_cnt_d  = frame_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (en) begin
               state_d = S_VBLANK;
               cnt_d   = '0;
            end
         end
         S_VBLANK: begin
            if (cnt_q == CntW'(VBlank - 1)) begin
               vb_last = 1'b1;
               state_d = S_FRONT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_FRONT: begin
            img_fv_d = 1'b1;
            row_d    = '0;
            px_d     = '0;
            if (cnt_q == CntW'(FrontPorch - 1)) begin
               state_d = S_LINE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_LINE: begin
            img_fv_d = 1'b1;
            img_lv_d = 1'b1;
            img_d_d  = pix_val;
            px_d     = px_q + 1'b1;
            if (cnt_q == CntW'(ImageWidth - 1)) begin
               state_d = S_HBLANK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_HBLANK: begin
            img_fv_d = 1'b1;
            if (cnt_q == CntW'(HBlank - 1)) begin
               cnt_d = '0;
               if (row_q == RowW'(ImageHeight - 1)) begin
                  state_d = S_END;
               end else begin
                  row_d   = row_q + 1'b1;
                  state_d = S_LINE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_END: begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            // END already stands in for the first blanking cycle of the next frame.
            if (en) begin
               if (VBlank == 1) begin
                  vb_last = 1'b1;
                  state_d = S_FRONT;
                  cnt_d   = '0;
               end else begin
                  state_d = S_VBLANK;
                  cnt_d   = CntW'(1);
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (vb_last) begin
         mode_d = mode;
         cval_d = const_val;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         row_q        <= '0;
         px_q         <= '0;
         mode_q       <= '0;
         cval_q       <= '0;
         img_d_q      <= '0;
         img_fv_q     <= 1'b0;
         img_lv_q     <= 1'b0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         row_q        <= row_d;
         px_q         <= px_d;
         mode_q       <= mode_d;
         cval_q       <= cval_d;
         img_d_q      <= img_d_d;
         img_fv_q     <= img_fv_d;
         img_lv_q     <= img_lv_d;
         frame_done_q <= frame_done_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign img_d      = img_d_q;
   assign img_fv     = img_fv_q;
   assign img_lv     = img_lv_q;
   assign frame_done = frame_done_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_img_pattern_gen.sv
// Directed bench for img_pattern_gen: a small 4x3 instance for timing/patterns and a 300-wide 8-bit instance for gradient wrap.
module tb_img_pattern_gen;
   localparam int W  = 4;
   localparam int H  = 3;
   localparam int VB = 2;
   localparam int FP = 2;
   localparam int HB = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_;
   logic        a_en, b_en;
   logic [1:0]  a_mode, b_mode;
   logic [11:0] a_cval;
   logic [7:0]  b_cval;
   logic [11:0] a_d;
   logic [7:0]  b_d;
   logic        a_fv, a_lv, a_done, b_fv, b_lv, b_done;
   logic [15:0] a_fcnt, b_fcnt;

   int errors = 0;
   int checks = 0;

   logic [11:0] pix_a [0:63];
   logic [7:0]  pix_b [0:1023];
   logic [11:0] exp_grid [12] = '{12'hFFF, 12'h000, 12'hFFF, 12'h000,
                                  12'h000, 12'h000, 12'h000, 12'h000,
                                  12'hFFF, 12'h000, 12'hFFF, 12'h000};

   img_pattern_gen #(.ImageWidth(W), .ImageHeight(H), .PixelWidth(12), .VBlank(VB),
                     .FrontPorch(FP), .HBlank(HB), .GridPitch(2)) dut_a (
      .clk(clk), .rst_(rst_), .en(a_en), .mode(a_mode), .const_val(a_cval),
      .img_d(a_d), .img_fv(a_fv), .img_lv(a_lv), .frame_done(a_done), .frame_cnt(a_fcnt));

   img_pattern_gen #(.ImageWidth(300), .ImageHeight(2), .PixelWidth(8), .VBlank(2),
                     .FrontPorch(2), .HBlank(2), .GridPitch(4)) dut_b (
      .clk(clk), .rst_(rst_), .en(b_en), .mode(b_mode), .const_val(b_cval),
      .img_d(b_d), .img_fv(b_fv), .img_lv(b_lv), .frame_done(b_done), .frame_cnt(b_fcnt));

   task automatic do_reset();
      @(negedge clk);
      rst_ = 1'b0;
      a_en = 1'b0;
      b_en = 1'b0;
      @(negedge clk);
      rst_ = 1'b1;
   endtask

   // Counts negedges until img_fv is seen high (the current sample counts as 0); -1 on timeout.
   task automatic wait_rise_a(input int budget, output int n);
      n = 0;
      while (a_fv !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (a_fv !== 1'b1) n = -1;
   endtask

   // Entered on the first img_fv=1 sample; returns on the first img_fv=0 sample (the END cycle).
   task automatic cap_a(input int drop_at, input int cval_at, output int fv_len, output int npx,
                        output int lvp, output int bad_d, output int done_in,
                        output logic done_end, output logic [15:0] cnt_end);
      logic prev_lv;
      fv_len = 0; npx = 0; lvp = 0; bad_d = 0; done_in = 0; prev_lv = 1'b0;
      while (a_fv === 1'b1 && fv_len < 200) begin
         if (a_lv === 1'b1 && !prev_lv) lvp++;
         if (a_lv === 1'b1) begin
            if (npx < 64) pix_a[npx] = a_d;
            npx++;
         end else if (a_d !== 12'h000) begin
            bad_d++;
         end
         if (a_done === 1'b1) done_in++;
         prev_lv = a_lv;
         fv_len++;
         if (fv_len == drop_at) a_en = 1'b0;
         if (fv_len == cval_at) a_cval = 12'h123;
         @(negedge clk);
      end
      done_end = a_done;
      cnt_end  = a_fcnt;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_ = 1'b0;
      a_en = 1'b0;
      @(negedge clk);
      checks++; if (a_fv !== 1'b0)      begin errors++; $display("FAIL reset_fv got=%b exp=0", a_fv); end
      checks++; if (a_lv !== 1'b0)      begin errors++; $display("FAIL reset_lv got=%b exp=0", a_lv); end
      checks++; if (a_d !== 12'h000)    begin errors++; $display("FAIL reset_d got=%h exp=000", a_d); end
      checks++; if (a_done !== 1'b0)    begin errors++; $display("FAIL reset_done got=%b exp=0", a_done); end
      checks++; if (a_fcnt !== 16'h0)   begin errors++; $display("FAIL reset_fcnt got=%h exp=0000", a_fcnt); end
      rst_ = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if (a_fv !== 1'b0)      begin errors++; $display("FAIL idle_fv got=%b exp=0", a_fv); end
   endtask

   task automatic test_counter();
      int n, fv_len, npx, lvp, bad_d, done_in;
      logic done_end;
      logic [15:0] cnt_end;
      do_reset();
      a_mode = 2'd0;
      a_en   = 1'b1;
      wait_rise_a(50, n);
      // Sampling edge is the first counted edge, fv rises VB+1 edges after it.
      checks++; if (n != VB + 2) begin errors++; $display("FAIL first_rise got=%0d exp=%0d", n, VB + 2); end
      cap_a(-1, -1, fv_len, npx, lvp, bad_d, done_in, done_end, cnt_end);
      checks++; if (fv_len != 20) begin errors++; $display("FAIL fv_span got=%0d exp=20", fv_len); end
      checks++; if (lvp != 3)     begin errors++; $display("FAIL lv_pulses got=%0d exp=3", lvp); end
      checks++; if (npx != 12)    begin errors++; $display("FAIL lv_cycles got=%0d exp=12", npx); end
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (pix_a[i] !== 12'(i)) begin errors++; $display("FAIL cnt_px%0d got=%h exp=%h", i, pix_a[i], 12'(i)); end
      end
      checks++; if (done_in != 0)     begin errors++; $display("FAIL done_in_frame got=%0d exp=0", done_in); end
      checks++; if (done_end !== 1'b1) begin errors++; $display("FAIL done_end got=%b exp=1", done_end); end
      checks++; if (cnt_end !== 16'd1) begin errors++; $display("FAIL fcnt1 got=%0d exp=1", cnt_end); end
      @(negedge clk);
      checks++; if (a_done !== 1'b0)  begin errors++; $display("FAIL done_width got=%b exp=0", a_done); end
      wait_rise_a(50, n);
      checks++; if (n + 1 != VB)      begin errors++; $display("FAIL vblank_gap got=%0d exp=%0d", n + 1, VB); end
      cap_a(-1, -1, fv_len, npx, lvp, bad_d, done_in, done_end, cnt_end);
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (pix_a[i] !== 12'(i)) begin errors++; $display("FAIL cnt2_px%0d got=%h exp=%h", i, pix_a[i], 12'(i)); end
      end
      checks++; if (cnt_end !== 16'd2) begin errors++; $display("FAIL fcnt2 got=%0d exp=2", cnt_end); end
   endtask

   task automatic test_grid();
      int n, fv_len, npx, lvp, bad_d, done_in;
      logic done_end;
      logic [15:0] cnt_end;
      do_reset();
      a_mode = 2'd1;
      a_en   = 1'b1;
      wait_rise_a(50, n);
      cap_a(-1, -1, fv_len, npx, lvp, bad_d, done_in, done_end, cnt_end);
      checks++; if (npx != 12) begin errors++; $display("FAIL grid_npx got=%0d exp=12", npx); end
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (pix_a[i] !== exp_grid[i]) begin errors++; $display("FAIL grid_px%0d got=%h exp=%h", i, pix_a[i], exp_grid[i]); end
      end
      checks++; if (bad_d != 0) begin errors++; $display("FAIL grid_blank_d got=%0d exp=0", bad_d); end
   endtask

   task automatic test_const();
      int n, fv_len, npx, lvp, bad_d, done_in;
      logic done_end;
      logic [15:0] cnt_end;
      do_reset();
      a_mode = 2'd2;
      a_cval = 12'hA5A;
      a_en   = 1'b1;
      wait_rise_a(50, n);
      cap_a(-1, 5, fv_len, npx, lvp, bad_d, done_in, done_end, cnt_end);
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (pix_a[i] !== 12'hA5A) begin errors++; $display("FAIL const1_px%0d got=%h exp=A5A", i, pix_a[i]); end
      end
      wait_rise_a(50, n);
      cap_a(-1, -1, fv_len, npx, lvp, bad_d, done_in, done_end, cnt_end);
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (pix_a[i] !== 12'h123) begin errors++; $display("FAIL const2_px%0d got=%h exp=123", i, pix_a[i]); end
      end
   endtask

   task automatic test_en_drop();
      int n, fv_len, npx, lvp, bad_d, done_in, busy;
      logic done_end;
      logic [15:0] cnt_end;
      do_reset();
      a_mode = 2'd0;
      a_en   = 1'b1;
      wait_rise_a(50, n);
      cap_a(9, -1, fv_len, npx, lvp, bad_d, done_in, done_end, cnt_end);
      checks++; if (lvp != 3)          begin errors++; $display("FAIL drop_lines got=%0d exp=3", lvp); end
      checks++; if (npx != 12)         begin errors++; $display("FAIL drop_npx got=%0d exp=12", npx); end
      checks++; if (done_end !== 1'b1) begin errors++; $display("FAIL drop_done got=%b exp=1", done_end); end
      busy = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (a_fv !== 1'b0 || a_lv !== 1'b0 || a_d !== 12'h000 || a_done !== 1'b0) busy++;
      end
      checks++; if (busy != 0)         begin errors++; $display("FAIL drop_idle got=%0d exp=0", busy); end
      checks++; if (a_fcnt !== 16'd1)  begin errors++; $display("FAIL drop_fcnt got=%0d exp=1", a_fcnt); end
      a_en = 1'b1;
      wait_rise_a(50, n);
      checks++; if (n - 1 != VB + 1)   begin errors++; $display("FAIL restart_rise got=%0d exp=%0d", n - 1, VB + 1); end
   endtask

   task automatic test_mid_reset();
      int n, fv_len, npx, lvp, bad_d, done_in;
      logic done_end;
      logic [15:0] cnt_end;
      do_reset();
      a_mode = 2'd0;
      a_en   = 1'b1;
      wait_rise_a(50, n);
      cap_a(-1, -1, fv_len, npx, lvp, bad_d, done_in, done_end, cnt_end);
      wait_rise_a(50, n);
      repeat (3) @(negedge clk);
      checks++; if (a_lv !== 1'b1)     begin errors++; $display("FAIL mid_inline got=%b exp=1", a_lv); end
      rst_ = 1'b0;
      @(negedge clk);
      checks++; if ({a_fv, a_lv, a_done} !== 3'b000) begin errors++; $display("FAIL mid_ctrl got=%b exp=000", {a_fv, a_lv, a_done}); end
      checks++; if (a_d !== 12'h000)   begin errors++; $display("FAIL mid_d got=%h exp=000", a_d); end
      checks++; if (a_fcnt !== 16'd0)  begin errors++; $display("FAIL mid_fcnt got=%0d exp=0", a_fcnt); end
      rst_ = 1'b1;
      wait_rise_a(50, n);
      checks++; if (n != VB + 2)       begin errors++; $display("FAIL mid_restart got=%0d exp=%0d", n, VB + 2); end
      cap_a(-1, -1, fv_len, npx, lvp, bad_d, done_in, done_end, cnt_end);
      checks++; if (fv_len != 20)      begin errors++; $display("FAIL mid_span got=%0d exp=20", fv_len); end
      checks++; if (pix_a[0] !== 12'd0 || pix_a[11] !== 12'd11)
         begin errors++; $display("FAIL mid_px got=%h,%h exp=000,00b", pix_a[0], pix_a[11]); end
      checks++; if (cnt_end !== 16'd1) begin errors++; $display("FAIL mid_fcnt1 got=%0d exp=1", cnt_end); end
   endtask

   task automatic test_gradient_wrap();
      int n, npx;
      logic found;
      do_reset();
      b_mode = 2'd3;
      force dut_b.frame_cnt_q = 16'hFFFE;
      @(negedge clk);
      release dut_b.frame_cnt_q;
      b_en = 1'b1;
      n = 0;
      while (b_fv !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      npx = 0;
      n = 0;
      while (b_fv === 1'b1 && n < 2000) begin
         if (b_lv === 1'b1) begin
            if (npx < 1024) pix_b[npx] = b_d;
            npx++;
         end
         n++;
         @(negedge clk);
      end
      checks++; if (npx != 600)           begin errors++; $display("FAIL grad_npx got=%0d exp=600", npx); end
      checks++; if (pix_b[255] !== 8'hFF) begin errors++; $display("FAIL grad_c255 got=%h exp=ff", pix_b[255]); end
      checks++; if (pix_b[256] !== 8'h00) begin errors++; $display("FAIL grad_c256 got=%h exp=00", pix_b[256]); end
      checks++; if (pix_b[300] !== 8'h01) begin errors++; $display("FAIL grad_r1c0 got=%h exp=01", pix_b[300]); end
      checks++; if (pix_b[599] !== 8'h2C) begin errors++; $display("FAIL grad_r1c299 got=%h exp=2c", pix_b[599]); end
      checks++; if (b_done !== 1'b1)      begin errors++; $display("FAIL grad_done got=%b exp=1", b_done); end
      checks++; if (b_fcnt !== 16'hFFFF)  begin errors++; $display("FAIL grad_fcnt got=%h exp=ffff", b_fcnt); end
      @(negedge clk);
      found = 1'b0;
      n = 0;
      while (!found && n < 1000) begin
         @(negedge clk);
         n++;
         if (b_done === 1'b1) found = 1'b1;
      end
      checks++; if (found !== 1'b1)       begin errors++; $display("FAIL wrap_done got=%b exp=1", found); end
      checks++; if (b_fcnt !== 16'h0000)  begin errors++; $display("FAIL wrap_fcnt got=%h exp=0000", b_fcnt); end
      b_en = 1'b0;
   endtask

   initial begin
      rst_   = 1'b0;
      a_en   = 1'b0;
      b_en   = 1'b0;
      a_mode = 2'd0;
      b_mode = 2'd0;
      a_cval = 12'h000;
      b_cval = 8'h00;
      test_reset();
      test_counter();
      test_grid();
      test_const();
      test_en_drop();
      test_mid_reset();
      test_gradient_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
